// File: rtl/rob_pkg.sv
// Shared widths, types and the allocation-range helper for the memory response reorder buffer.
// Depth is 2**ROB_IDWIDTH, so the ID space and the slot index are the same thing.
package rob_pkg;
  localparam int ROB_IDWIDTH = 4;
  localparam int ROB_AWIDTH  = 32;
  localparam int ROB_DWIDTH  = 32;
  localparam int ROB_DEPTH   = 1 << ROB_IDWIDTH;

  typedef logic [ROB_IDWIDTH-1:0] rob_id_t;
  typedef logic [ROB_IDWIDTH:0]   rob_cnt_t;
  typedef logic [ROB_DWIDTH-1:0]  rob_data_t;
  typedef logic [ROB_AWIDTH-1:0]  rob_addr_t;

  // True when id lies in the live window [retire_ptr, retire_ptr + count) modulo depth.
  function automatic logic rob_in_flight(rob_id_t id, rob_id_t retire_ptr, rob_cnt_t count);
    rob_id_t ofs;
    ofs = id - retire_ptr;
    return ({1'b0, ofs} < count);
  endfunction
endpackage

// File: rtl/rob_ptr_ctrl.sv
// Allocation/retire pointers and occupancy count; pointers wrap modulo depth, updates land at the edge.
// No backpressure of its own: full is exported and the caller must not accept while it is high.
module rob_ptr_ctrl
  import rob_pkg::*;
(
  input  logic     clk,
  input  logic     rst_,
  input  logic     accept,
  input  logic     retire,
  output rob_id_t  alloc_ptr,
  output rob_id_t  retire_ptr,
  output rob_cnt_t count,
  output logic     full
);
  logic empty;

  assign full  = (count == rob_cnt_t'(ROB_DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      alloc_ptr  <= '0;
      retire_ptr <= '0;
      count      <= '0;
    end else begin
      if (accept)
        alloc_ptr <= alloc_ptr + rob_id_t'(1);
      if (retire && !empty)
        retire_ptr <= retire_ptr + rob_id_t'(1);
      // Simultaneous accept and retire leave the occupancy unchanged.
      if (accept && !(retire && !empty))
        count <= count + rob_cnt_t'(1);
      else if (!accept && retire && !empty)
        count <= count - rob_cnt_t'(1);
    end
  end
endmodule

// File: rtl/mem_rsp_rob.sv
// Reorder buffer: tags in-order reads with free IDs, returns out-of-order data in request order, >=1 cycle rsp->out.
// Stalls upstream when full (no full bypass); out held under out_rsp_rdy=0. ROB_ERR_CHK_EN enables rob_err checking.
module mem_rsp_rob
  import rob_pkg::*;
(
  input  logic      clk,
  input  logic      rst_,
  input  logic      in_req_val,
  output logic      in_req_rdy,
  input  rob_addr_t in_req_addr,
  output logic      mem_req_val,
  output rob_addr_t mem_req_addr,
  output rob_id_t   mem_req_ID,
  input  logic      mem_rsp_val,
  input  rob_id_t   mem_rsp_ID,
  input  rob_data_t mem_rsp_data,
  output logic      out_rsp_val,
  input  logic      out_rsp_rdy,
  output rob_data_t out_rsp_data,
  output logic      rob_err
);
  rob_id_t        alloc_ptr;
  rob_id_t        retire_ptr;
  rob_cnt_t       count;
  logic           full;
  logic           accept;
  logic           retire;
  logic           rsp_wr;
  logic [ROB_DEPTH-1:0] done;
  rob_data_t      data [ROB_DEPTH];

  rob_ptr_ctrl u_ptr (
    .clk        (clk),
    .rst_       (rst_),
    .accept     (accept),
    .retire     (retire),
    .alloc_ptr  (alloc_ptr),
    .retire_ptr (retire_ptr),
    .count      (count),
    .full       (full)
  );

  assign in_req_rdy   = !full;
  assign accept       = in_req_val && !full;
  assign mem_req_val  = accept;
  assign mem_req_addr = in_req_addr;
  assign mem_req_ID   = alloc_ptr;

  // A stray done bit on an empty ROB must not present data or underflow the count.
  assign out_rsp_val  = done[retire_ptr] && (count != '0);
  assign out_rsp_data = data[retire_ptr];
  assign retire       = out_rsp_val && out_rsp_rdy;

`ifdef ROB_ERR_CHK_EN
  logic rsp_ok;
  assign rsp_ok = rob_in_flight(mem_rsp_ID, retire_ptr, count) && !done[mem_rsp_ID];
  assign rsp_wr = mem_rsp_val && rsp_ok;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      rob_err <= 1'b0;
    else if (mem_rsp_val && !rsp_ok)
      rob_err <= 1'b1;
  end
`else
  assign rsp_wr  = mem_rsp_val;
  assign rob_err = 1'b0;
`endif

  // Clear is applied after set so a retire wins over a same-cycle response to that slot.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      done <= '0;
    end else begin
      if (rsp_wr)
        done[mem_rsp_ID] <= 1'b1;
      if (retire)
        done[retire_ptr] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_wr)
      data[mem_rsp_ID] <= mem_rsp_data;
  end
endmodule

// File: tb/tb_mem_rsp_rob.sv
// Directed bench for mem_rsp_rob: memory echoes the request address as response data.
module tb_mem_rsp_rob;
  logic        clk = 1'b0;
  logic        rst_;
  logic        in_req_val;
  logic        in_req_rdy;
  logic [31:0] in_req_addr;
  logic        mem_req_val;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_ID;
  logic        mem_rsp_val;
  logic [3:0]  mem_rsp_ID;
  logic [31:0] mem_rsp_data;
  logic        out_rsp_val;
  logic        out_rsp_rdy;
  logic [31:0] out_rsp_data;
  logic        rob_err;

  int checks = 0;
  int errors = 0;

`ifdef ROB_ERR_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_rsp_rob dut (
    .clk          (clk),
    .rst_         (rst_),
    .in_req_val   (in_req_val),
    .in_req_rdy   (in_req_rdy),
    .in_req_addr  (in_req_addr),
    .mem_req_val  (mem_req_val),
    .mem_req_addr (mem_req_addr),
    .mem_req_ID   (mem_req_ID),
    .mem_rsp_val  (mem_rsp_val),
    .mem_rsp_ID   (mem_rsp_ID),
    .mem_rsp_data (mem_rsp_data),
    .out_rsp_val  (out_rsp_val),
    .out_rsp_rdy  (out_rsp_rdy),
    .out_rsp_data (out_rsp_data),
    .rob_err      (rob_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    in_req_val = 1'b0; in_req_addr = '0;
    mem_rsp_val = 1'b0; mem_rsp_ID = '0; mem_rsp_data = '0;
    out_rsp_rdy = 1'b0;
    tick(); tick();
    rst_ = 1'b1;
    #1;
  endtask

  initial begin
    // ---------------- reset state
    do_reset();
    chk("rst_in_req_rdy", 64'(in_req_rdy), 64'd1);
    chk("rst_mem_req_val", 64'(mem_req_val), 64'd0);
    chk("rst_out_rsp_val", 64'(out_rsp_val), 64'd0);
    chk("rst_rob_err", 64'(rob_err), 64'd0);

    // ---------------- 1: single request, response 3 cycles later
    in_req_val = 1'b1; in_req_addr = 32'h100;
    #1;
    chk("t1_mem_req_val", 64'(mem_req_val), 64'd1);
    chk("t1_mem_req_ID", 64'(mem_req_ID), 64'd0);
    chk("t1_mem_req_addr", 64'(mem_req_addr), 64'h100);
    tick();
    in_req_val = 1'b0;
    tick(); tick();
    mem_rsp_val = 1'b1; mem_rsp_ID = 4'd0; mem_rsp_data = 32'h100;
    #1;
    chk("t1_no_bypass", 64'(out_rsp_val), 64'd0);
    tick();
    mem_rsp_val = 1'b0;
    #1;
    chk("t1_out_val", 64'(out_rsp_val), 64'd1);
    chk("t1_out_data", 64'(out_rsp_data), 64'h100);
    out_rsp_rdy = 1'b1;
    tick();
    out_rsp_rdy = 1'b0;
    chk("t1_retired", 64'(out_rsp_val), 64'd0);

    // ---------------- 2: out-of-order responses 2,0,1
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_req_val = 1'b1; in_req_addr = 32'hA0 + 32'(i);
      #1;
      chk("t2_req_ID", 64'(mem_req_ID), 64'(i));
      tick();
    end
    in_req_val = 1'b0;
    mem_rsp_val = 1'b1; mem_rsp_ID = 4'd2; mem_rsp_data = 32'hA2;
    tick();
    chk("t2_wait_head", 64'(out_rsp_val), 64'd0);
    mem_rsp_ID = 4'd0; mem_rsp_data = 32'hA0;
    tick();
    mem_rsp_val = 1'b0;
    chk("t2_out0_val", 64'(out_rsp_val), 64'd1);
    chk("t2_out0_data", 64'(out_rsp_data), 64'hA0);
    out_rsp_rdy = 1'b1;
    mem_rsp_val = 1'b1; mem_rsp_ID = 4'd1; mem_rsp_data = 32'hA1;
    tick();
    mem_rsp_val = 1'b0;
    chk("t2_out1_val", 64'(out_rsp_val), 64'd1);
    chk("t2_out1_data", 64'(out_rsp_data), 64'hA1);
    tick();
    chk("t2_out2_val", 64'(out_rsp_val), 64'd1);
    chk("t2_out2_data", 64'(out_rsp_data), 64'hA2);
    tick();
    out_rsp_rdy = 1'b0;
    chk("t2_drained", 64'(out_rsp_val), 64'd0);

    // ---------------- 3: fill 16, 17th held, retire one, wrap to ID0
    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_req_val = 1'b1; in_req_addr = 32'h200 + 32'(i);
      #1;
      chk("t3_fill_ID", 64'(mem_req_ID), 64'(i));
      tick();
    end
    in_req_addr = 32'h210;
    #1;
    chk("t3_full_rdy", 64'(in_req_rdy), 64'd0);
    chk("t3_held_req", 64'(mem_req_val), 64'd0);
    tick();
    chk("t3_still_full", 64'(in_req_rdy), 64'd0);
    mem_rsp_val = 1'b1; mem_rsp_ID = 4'd0; mem_rsp_data = 32'h200;
    tick();
    mem_rsp_val = 1'b0;
    out_rsp_rdy = 1'b1;
    #1;
    chk("t3_head_data", 64'(out_rsp_data), 64'h200);
    chk("t3_no_full_bypass", 64'(in_req_rdy), 64'd0);
    tick();
    out_rsp_rdy = 1'b0;
    #1;
    chk("t3_rdy_after_retire", 64'(in_req_rdy), 64'd1);
    chk("t3_wrap_val", 64'(mem_req_val), 64'd1);
    chk("t3_wrap_ID", 64'(mem_req_ID), 64'd0);
    chk("t3_wrap_addr", 64'(mem_req_addr), 64'h210);
    tick();
    in_req_val = 1'b0;
    chk("t3_full_again", 64'(in_req_rdy), 64'd0);

    // ---------------- 4: stall head for 5 cycles, then one retire per cycle
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_req_val = 1'b1; in_req_addr = 32'h300 + 32'(i);
      tick();
    end
    in_req_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rsp_val = 1'b1; mem_rsp_ID = 4'(i); mem_rsp_data = 32'h300 + 32'(i);
      tick();
    end
    mem_rsp_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_val", 64'(out_rsp_val), 64'd1);
      chk("t4_stall_data", 64'(out_rsp_data), 64'h300);
      tick();
    end
    out_rsp_rdy = 1'b1;
    tick();
    chk("t4_ret1_data", 64'(out_rsp_data), 64'h301);
    tick();
    chk("t4_ret2_data", 64'(out_rsp_data), 64'h302);
    tick();
    out_rsp_rdy = 1'b0;
    chk("t4_drained", 64'(out_rsp_val), 64'd0);

    // ---------------- 5: response to an unallocated slot on an empty ROB
    do_reset();
    mem_rsp_val = 1'b1; mem_rsp_ID = 4'd5; mem_rsp_data = 32'h55;
    tick();
    mem_rsp_val = 1'b0;
    chk("t5_rob_err", 64'(rob_err), 64'(ERR_EXP));
    chk("t5_out_val", 64'(out_rsp_val), 64'd0);
    tick(); tick();
    chk("t5_rob_err_sticky", 64'(rob_err), 64'(ERR_EXP));

    // ---------------- 6: reset with 4 in flight
    do_reset();
    chk("t6_err_cleared", 64'(rob_err), 64'd0);
    for (int i = 0; i < 4; i++) begin
      in_req_val = 1'b1; in_req_addr = 32'h400 + 32'(i);
      tick();
    end
    in_req_val = 1'b0;
    mem_rsp_val = 1'b1; mem_rsp_ID = 4'd0; mem_rsp_data = 32'h400;
    tick();
    mem_rsp_val = 1'b0;
    chk("t6_pre_out_val", 64'(out_rsp_val), 64'd1);
    rst_ = 1'b0;
    #1;
    chk("t6_rst_in_rdy", 64'(in_req_rdy), 64'd1);
    chk("t6_rst_out_val", 64'(out_rsp_val), 64'd0);
    tick();
    rst_ = 1'b1;
    in_req_val = 1'b1; in_req_addr = 32'h500;
    #1;
    chk("t6_new_req_val", 64'(mem_req_val), 64'd1);
    chk("t6_new_req_ID", 64'(mem_req_ID), 64'd0);
    tick();
    in_req_val = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
